// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-scheduling shuffle.
package rc4_pkg;

  localparam int S_DEPTH           = 256;
  localparam int KEY_BYTES_DEFAULT = 3;

  typedef enum logic [3:0] {
    IDLE,
    RD_SI,
    WAIT_SI,
    LAT_SI,
    RD_SJ,
    WAIT_SJ,
    LAT_SJ,
    WR_SI,
    WR_SJ,
    INC,
    DONE
  } state_t;

endpackage

// File: rtl/shuffle_swap_fsm_key_byte_sel.sv
// Picks one byte of the latched secret key; byte 0 is the most significant.
module key_byte_sel #(
  parameter int KEY_BYTES = 3,
  parameter int KIDX_W    = 2
) (
  input  logic [8*KEY_BYTES-1:0] key,
  input  logic [KIDX_W-1:0]      idx,
  output logic [7:0]             key_byte
);

  // Plain mux over the key bytes, index 0 selects the top byte
  always_comb begin
    key_byte = '0;
    for (int k = 0; k < KEY_BYTES; k++) begin
      if (idx == KIDX_W'(k)) key_byte = key[8*(KEY_BYTES-1-k) +: 8];
    end
  end

endmodule

// File: rtl/shuffle_swap_fsm.sv
// RC4 KSA shuffle: for each i, j += s[i] + key[i mod KEY_BYTES], swap s[i]/s[j].
// All memory-side outputs are registered and set on the transition into a state.
module shuffle_swap_fsm
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = KEY_BYTES_DEFAULT,
  parameter int RD_LAT    = 2
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  input  logic [7:0]             s_q,
  output logic [7:0]             s_address,
  output logic [7:0]             s_wrdata,
  output logic                   s_wren,
  output logic                   busy,
  output logic                   done
);

  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam int WAIT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
  localparam logic [7:0] LAST_I = 8'(S_DEPTH - 1);

  state_t                 state_q, state_d;
  logic [7:0]             i_q, i_d, j_q, j_d;
  logic [7:0]             si_q, si_d, sj_q, sj_d;
  logic [KIDX_W-1:0]      kidx_q, kidx_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic [8*KEY_BYTES-1:0] key_q, key_d;
  logic [7:0]             s_address_q, s_address_d;
  logic [7:0]             s_wrdata_q, s_wrdata_d;
  logic                   s_wren_q, s_wren_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [7:0]             key_byte;

  key_byte_sel #(
    .KEY_BYTES(KEY_BYTES),
    .KIDX_W   (KIDX_W)
  ) u_key_byte_sel (
    .key     (key_q),
    .idx     (kidx_q),
    .key_byte(key_byte)
  );

  // Next-state and next-output logic; outputs describe the state being entered
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    si_d        = si_q;
    sj_d        = sj_q;
    kidx_d      = kidx_q;
    wait_d      = wait_q;
    key_d       = key_q;
    s_address_d = s_address_q;
    s_wrdata_d  = s_wrdata_q;
    s_wren_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RD_SI;
          i_d         = '0;
          j_d         = '0;
          kidx_d      = '0;
          key_d       = secret_key;
          s_address_d = '0;
        end
      end
      RD_SI: begin
        wait_d  = '0;
        state_d = (RD_LAT > 1) ? WAIT_SI : LAT_SI;
      end
      WAIT_SI: begin
        if (wait_q == WAIT_W'(RD_LAT - 2)) state_d = LAT_SI;
        else                               wait_d  = wait_q + 1'b1;
      end
      LAT_SI: begin
        si_d        = s_q;
        j_d         = j_q + s_q + key_byte;
        s_address_d = j_d;
        state_d     = RD_SJ;
      end
      RD_SJ: begin
        wait_d  = '0;
        state_d = (RD_LAT > 1) ? WAIT_SJ : LAT_SJ;
      end
      WAIT_SJ: begin
        if (wait_q == WAIT_W'(RD_LAT - 2)) state_d = LAT_SJ;
        else                               wait_d  = wait_q + 1'b1;
      end
      LAT_SJ: begin
        sj_d        = s_q;
        s_address_d = i_q;
        s_wrdata_d  = s_q;
        s_wren_d    = 1'b1;
        state_d     = WR_SI;
      end
      WR_SI: begin
        s_address_d = j_q;
        s_wrdata_d  = si_q;
        s_wren_d    = 1'b1;
        state_d     = WR_SJ;
      end
      WR_SJ: begin
        state_d = INC;
      end
      INC: begin
        if (i_q == LAST_I) begin
          state_d = DONE;
        end else begin
          i_d         = i_q + 8'd1;
          kidx_d      = (kidx_q == KIDX_W'(KEY_BYTES - 1)) ? '0 : kidx_q + 1'b1;
          s_address_d = i_d;
          state_d     = RD_SI;
        end
      end
      DONE: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Losing start while busy abandons the shuffle without another write
    if (busy_q && !start) begin
      state_d  = IDLE;
      s_wren_d = 1'b0;
    end

    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
  end

  // State and registered outputs, cleared asynchronously by reset
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      i_q         <= '0;
      j_q         <= '0;
      si_q        <= '0;
      sj_q        <= '0;
      kidx_q      <= '0;
      wait_q      <= '0;
      key_q       <= '0;
      s_address_q <= '0;
      s_wrdata_q  <= '0;
      s_wren_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      kidx_q      <= kidx_d;
      wait_q      <= wait_d;
      key_q       <= key_d;
      s_address_q <= s_address_d;
      s_wrdata_q  <= s_wrdata_d;
      s_wren_q    <= s_wren_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign s_address = s_address_q;
  assign s_wrdata  = s_wrdata_q;
  assign s_wren    = s_wren_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_shuffle_swap_fsm.sv
// Bench for shuffle_swap_fsm: 2-cycle-latency S memory model plus a software KSA reference.
module tb_shuffle_swap_fsm;

  localparam int KB = 3;

  logic          CLOCK_50;
  logic          reset;
  logic          start;
  logic [8*KB-1:0] secret_key;
  logic [7:0]    s_q;
  logic [7:0]    s_address;
  logic [7:0]    s_wrdata;
  logic          s_wren;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [256];
  logic [7:0] exp_mem [256];
  logic [7:0] addr_r, q_r;
  logic       init_mem = 1'b0;
  logic [7:0] wr_addr_q [$];
  logic [7:0] wr_data_q [$];

  shuffle_swap_fsm #(.KEY_BYTES(KB), .RD_LAT(2)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .start     (start),
    .secret_key(secret_key),
    .s_q       (s_q),
    .s_address (s_address),
    .s_wrdata  (s_wrdata),
    .s_wren    (s_wren),
    .busy      (busy),
    .done      (done)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  assign s_q = q_r;

  // Synchronous RAM: registered address then registered data (read latency 2), write log
  always @(posedge CLOCK_50) begin
    addr_r <= s_address;
    q_r    <= mem[addr_r];
    if (init_mem) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (s_wren === 1'b1) begin
      mem[s_address] <= s_wrdata;
      wr_addr_q.push_back(s_address);
      wr_data_q.push_back(s_wrdata);
    end
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Textbook RC4 key schedule on an identity array
  task automatic ref_ksa(input logic [8*KB-1:0] key);
    logic [7:0] j, t;
    logic [7:0] kb;
    for (int k = 0; k < 256; k++) exp_mem[k] = 8'(k);
    j = 0;
    for (int i = 0; i < 256; i++) begin
      kb = 8'(key >> (8 * (KB - 1 - (i % KB))));
      j = j + exp_mem[i] + kb;
      t = exp_mem[i];
      exp_mem[i] = exp_mem[j];
      exp_mem[j] = t;
    end
  endtask

  task automatic load_identity();
    init_mem = 1'b1;
    tick();
    init_mem = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  // Full run from IDLE; returns edges from the start-sampling edge to done
  task automatic run_shuffle(input logic [8*KB-1:0] key, input int chg_at,
                             input logic [8*KB-1:0] chg_key, output int n);
    load_identity();
    secret_key = key;
    start = 1'b1;
    tick();
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      if (n == chg_at) secret_key = chg_key;
      tick();
      n++;
    end
  endtask

  task automatic check_mem(input string name, input logic [8*KB-1:0] key);
    int bad = 0;
    ref_ksa(key);
    for (int k = 0; k < 256; k++) if (mem[k] !== exp_mem[k]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d bytes differ from model, need 0", name, bad);
    end
  endtask

  task automatic check_cycles(input string name, input int n);
    checks++;
    if (n != 2304) begin
      errors++;
      $display("FAIL %s: done after %0d cycles, need 2304", name, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    secret_key = '0;
    tick();
    tick();
    checks++;
    if ({s_address, s_wrdata, s_wren, busy, done} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%h data=%h wren=%b busy=%b done=%b, need all 0",
               s_address, s_wrdata, s_wren, busy, done);
    end
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || wr_addr_q.size() != 0) begin
      errors++;
      $display("FAIL idle_no_start: busy=%b writes=%0d, need 0 and 0", busy, wr_addr_q.size());
    end
  endtask

  task automatic test_key_010203();
    int n;
    run_shuffle(24'h010203, -1, '0, n);
    check_cycles("cycles_010203", n);
    checks++;
    if (wr_addr_q.size() < 2 || wr_addr_q[0] !== 8'd0 || wr_data_q[0] !== 8'h01 ||
        wr_addr_q[1] !== 8'd1 || wr_data_q[1] !== 8'h00) begin
      errors++;
      $display("FAIL first_writes_010203: got %0d writes, need addr0<=01 then addr1<=00",
               wr_addr_q.size());
    end
    checks++;
    if (wr_addr_q.size() != 512) begin
      errors++;
      $display("FAIL write_count_010203: got %0d, need 512", wr_addr_q.size());
    end
    check_mem("mem_010203", 24'h010203);
  endtask

  task automatic test_hold_done();
    int bad = 0;
    wr_addr_q.delete();
    wr_data_q.delete();
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || wr_addr_q.size() != 0) begin
      errors++;
      $display("FAIL hold_done: %0d cycles lost done, %0d writes, need 0 and 0", bad, wr_addr_q.size());
    end
    start = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_release: done=%b busy=%b, need 0 0", done, busy);
    end
  endtask

  task automatic test_zero_key();
    int n;
    run_shuffle(24'h000000, -1, '0, n);
    check_cycles("cycles_zero", n);
    checks++;
    if (wr_addr_q.size() < 4 ||
        wr_addr_q[0] !== 8'd0 || wr_data_q[0] !== 8'd0 || wr_addr_q[1] !== 8'd0 || wr_data_q[1] !== 8'd0 ||
        wr_addr_q[2] !== 8'd1 || wr_data_q[2] !== 8'd1 || wr_addr_q[3] !== 8'd1 || wr_data_q[3] !== 8'd1) begin
      errors++;
      $display("FAIL zero_key_writes: got %0d writes, need (0,0)(0,0)(1,1)(1,1) first", wr_addr_q.size());
    end
    check_mem("mem_zero", 24'h000000);
    start = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    int n;
    int bad = 0;
    load_identity();
    secret_key = 24'h5a3c81;
    start = 1'b1;
    tick();
    for (int k = 0; k < 499; k++) tick();
    start = 1'b0;
    tick();
    wr_addr_q.delete();
    wr_data_q.delete();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || s_wren !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b done=%b wren=%b, need 0 0 0", busy, done, s_wren);
    end
    for (int k = 0; k < 50; k++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || wr_addr_q.size() != 0) begin
      errors++;
      $display("FAIL abort_quiet: %0d bad cycles, %0d writes, need 0 and 0", bad, wr_addr_q.size());
    end
    run_shuffle(24'h5a3c81, -1, '0, n);
    check_cycles("cycles_restart", n);
    check_mem("mem_restart", 24'h5a3c81);
    start = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    int guard = 0;
    load_identity();
    secret_key = 24'hc0ffee;
    start = 1'b1;
    tick();
    while (!(s_wren === 1'b1 && wr_addr_q.size() >= 20 && (wr_addr_q.size() % 2) == 0) && guard < 500) begin
      tick();
      guard++;
    end
    checks++;
    if (guard >= 500) begin
      errors++;
      $display("FAIL reach_wr_si: no write cycle within %0d cycles, need one", guard);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({s_address, s_wrdata, s_wren, busy, done} !== 19'd0) begin
      errors++;
      $display("FAIL async_reset: got addr=%h data=%h wren=%b busy=%b done=%b, need all 0",
               s_address, s_wrdata, s_wren, busy, done);
    end
    start = 1'b0;
    #2 reset = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if (busy !== 1'b0 || wr_addr_q.size() != 0) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b writes=%0d, need 0 and 0", busy, wr_addr_q.size());
    end
    start = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_start: busy=%b, need 1", busy);
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_key_change();
    int n;
    logic [8*KB-1:0] k0, k1;
    k0 = 24'($urandom);
    k1 = ~k0;
    run_shuffle(k0, 10, k1, n);
    check_cycles("cycles_key_change", n);
    check_mem("mem_key_change", k0);
    start = 1'b0;
    tick();
  endtask

  task automatic test_random_keys();
    int n;
    logic [8*KB-1:0] k;
    for (int r = 0; r < 2; r++) begin
      k = 24'($urandom);
      run_shuffle(k, -1, '0, n);
      check_cycles("cycles_random", n);
      check_mem("mem_random", k);
      start = 1'b0;
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    secret_key = '0;
    test_reset();
    test_key_010203();
    test_hold_done();
    test_zero_key();
    test_abort();
    test_async_reset();
    test_key_change();
    test_random_keys();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
